// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer: read-side sequencer for the 16Kx16 packet-buffer SRAM.
// Takes one descriptor (start address, word count) at a time, issues read strobes to an SRAM
// with a fixed 1-cycle read latency, and captures the returned words into a 2-entry skid FIFO.
// The captured words are streamed out on a valid/ready interface with an end-of-packet flag.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   descriptor handshake; req_addr_i = first word, req_len_i = word count
//   sram_rd_en_o/addr_o   SRAM read strobe and address
//   sram_dout_i           SRAM read data, valid the cycle after sram_rd_en_o
//   out_valid_o/ready_i   output stream handshake; out_data_o word, out_last_o end of packet
//   done_o                one-cycle pulse after the last word handshakes (or after a len=0 accept)
//
// Optional feature: define SRAM_RD_BYPASS_EN to forward sram_dout_i combinationally to the output
// when the FIFO is empty, which saves one cycle of latency.
module sram_rd_streamer #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [LEN_W-1:0]  req_len_i,
  output logic              sram_rd_en_o,
  output logic [ADDR_W-1:0] sram_rd_addr_o,
  input  logic [DATA_W-1:0] sram_dout_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              done_o
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              req_ready_q;
  logic              done_q;
  logic              inflight_q;       // a read was issued last cycle; its data is on sram_dout_i
  logic              inflight_last_q;  // that read was the final word of the packet

  logic [DATA_W-1:0] fifo_data_q [2];
  logic [1:0]        fifo_last_q;
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        cnt_q;

  logic       fifo_empty;
  logic       pop;
  logic       fifo_pop;
  logic       push;
  logic       issue;
  logic       last_hs;
  logic [2:0] occ_after;

  assign fifo_empty = (cnt_q == 2'd0);

`ifdef SRAM_RD_BYPASS_EN
  logic byp;
  // Returning word goes straight out when nothing older is queued ahead of it.
  assign byp         = fifo_empty && inflight_q;
  assign out_valid_o = !fifo_empty || inflight_q;
  assign out_data_o  = byp ? sram_dout_i : fifo_data_q[rd_ptr_q];
  assign out_last_o  = byp ? inflight_last_q : fifo_last_q[rd_ptr_q];
  assign push        = inflight_q && !(byp && out_ready_i);
`else
  assign out_valid_o = !fifo_empty;
  assign out_data_o  = fifo_data_q[rd_ptr_q];
  assign out_last_o  = fifo_last_q[rd_ptr_q];
  assign push        = inflight_q;
`endif

  assign pop      = out_valid_o && out_ready_i;
  assign fifo_pop = pop && !fifo_empty;
  assign last_hs  = pop && out_last_o;

  // Slots committed after this cycle: queued + in flight - leaving now. pop implies occupancy >= 1.
  assign occ_after = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
  assign issue     = (state_q == StRead) && (rem_q != '0) && (occ_after < 3'd2);

  assign sram_rd_en_o   = issue;
  assign sram_rd_addr_o = addr_q;
  assign req_ready_o    = req_ready_q;
  assign done_o         = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      rem_q           <= '0;
      req_ready_q     <= 1'b0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue && (rem_q == LEN_W'(1));
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            addr_q <= req_addr_i;
            rem_q  <= req_len_i;
            if (req_len_i != '0) begin
              state_q     <= StRead;
              req_ready_q <= 1'b0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StRead: begin
          if (issue) begin
            addr_q <= addr_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
            rem_q  <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (last_hs) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            done_q      <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      cnt_q          <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= sram_dout_i;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, fifo_pop};
    end
  end

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Self-checking bench for sram_rd_streamer. A behavioural SRAM model supplies data; the driver
// pushes expected addresses and words into queues on each descriptor acceptance, and a monitor
// on the falling edge pops and compares whenever a read strobe or an output handshake occurs.
module tb_sram_rd_streamer;

`ifdef SRAM_RD_BYPASS_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [13:0] req_addr = '0;
  logic [13:0] req_len = '0;
  logic        sram_rd_en;
  logic [13:0] sram_rd_addr;
  logic [15:0] sram_dout = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
  logic        done;

  sram_rd_streamer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .req_len_i     (req_len),
    .sram_rd_en_o  (sram_rd_en),
    .sram_rd_addr_o(sram_rd_addr),
    .sram_dout_i   (sram_dout),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_last_o    (out_last),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16384];
  always @(posedge clk) if (sram_rd_en) sram_dout <= mem[sram_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: ready always high, 1: pattern 1,0,0,1 repeating, 2: random
  int ready_mode = 0;
  int phase = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       out_ready = (phase % 4 == 0) || (phase % 4 == 3);
      2:       out_ready = ($urandom % 3) != 0;
      default: out_ready = 1'b1;
    endcase
    phase = phase + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  logic [13:0] exp_addr_q[$];
  logic [16:0] exp_q[$];  // {last, data}
  int acc_log[$], rd_log[$], vld_log[$], hs_log[$], done_log[$];

  task automatic clear_logs();
    acc_log.delete(); rd_log.delete(); vld_log.delete(); hs_log.delete(); done_log.delete();
  endtask

  // Monitor / scoreboard
  int outstanding = 0;
  int popi;
  bit prev_stall = 0;
  bit prev_valid = 0;
  logic [15:0] prev_data;
  logic        prev_last;
  logic [16:0] e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_addr_q.delete();
      outstanding = 0;
      prev_stall = 0;
      prev_valid = 0;
    end else begin
      popi = int'(out_valid && out_ready);
      if (req_valid && req_ready) acc_log.push_back(cyc);
      if (sram_rd_en) begin
        rd_log.push_back(cyc);
        check("rd_occupancy", int'(outstanding - popi + 1 <= 2), 1);
        if (exp_addr_q.size() == 0) check("rd_unexpected", int'(sram_rd_en), 0);
        else check("rd_addr", int'(sram_rd_addr), int'(exp_addr_q.pop_front()));
      end
      outstanding = outstanding + int'(sram_rd_en) - popi;
      if (prev_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(prev_data));
        check("stall_last", int'(out_last), int'(prev_last));
      end
      if (out_valid && !prev_valid) vld_log.push_back(cyc);
      if (popi != 0) begin
        hs_log.push_back(cyc);
        if (exp_q.size() == 0) check("out_unexpected", int'(out_valid), 0);
        else begin
          e = exp_q.pop_front();
          check("out_data", int'(out_data), int'(e[15:0]));
          check("out_last", int'(out_last), int'(e[16]));
        end
      end
      if (done) done_log.push_back(cyc);
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send(input logic [13:0] a, input logic [13:0] l);
    bit ok;
    ok = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    check("req_accept_timeout", int'(ok), 1);
    if (ok) begin
      for (int i = 0; i < int'(l); i++) begin
        exp_addr_q.push_back(14'((int'(a) + i) % 16384));
        exp_q.push_back({i == int'(l) - 1, mem[(int'(a) + i) % 16384]});
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int want);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done_log.size() >= want) break;
    end
    check("done_timeout", int'(done_log.size() >= want), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rd_en", int'(sram_rd_en), 0);
    check("rst_rd_addr", int'(sram_rd_addr), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    check("post_rst_req_ready", int'(req_ready), 1);
    check("post_rst_out_valid", int'(out_valid), 0);
    check("post_rst_done", int'(done), 0);
    @(posedge clk);
    #1;
  endtask

  int t0;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Basic len=4 with latency checks
    clear_logs();
    send(14'h0100, 14'd4);
    wait_done(1);
    t0 = qget(acc_log, 0);
    check("t1_rd_count", rd_log.size(), 4);
    check("t1_first_rd", qget(rd_log, 0), t0 + 1);
    check("t1_last_rd", qget(rd_log, 3), t0 + 4);
    check("t1_first_valid", qget(vld_log, 0), t0 + Lat);
    check("t1_last_hs", qget(hs_log, 3), t0 + Lat + 3);
    check("t1_done", qget(done_log, 0), t0 + 4 + Lat);
    check("t1_exp_empty", exp_q.size(), 0);

    // Address wrap
    clear_logs();
    send(14'h3FFE, 14'd3);
    wait_done(1);
    check("t2_words", hs_log.size(), 3);
    check("t2_addr_left", exp_addr_q.size(), 0);

    // Back-to-back: second request held until the done cycle
    clear_logs();
    send(14'h0010, 14'd4);
    send(14'h0020, 14'd2);
    wait_done(2);
    check("t3_b2b_accept", qget(acc_log, 1), qget(done_log, 0));
    check("t3_b2b_gap", qget(vld_log, 1) - qget(hs_log, 3), Lat + 1);

    // Stalls with ready pattern 1,0,0,1
    ready_mode = 1;
    clear_logs();
    send(14'h0400, 14'd8);
    wait_done(1);
    check("t4_words", hs_log.size(), 8);
    check("t4_exp_empty", exp_q.size(), 0);
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Empty packet, then another accepted the very next cycle
    clear_logs();
    send(14'h0055, 14'd0);
    send(14'h0060, 14'd1);
    wait_done(2);
    check("t5_len0_done", qget(done_log, 0), qget(acc_log, 0) + 1);
    check("t5_next_accept", qget(acc_log, 1), qget(acc_log, 0) + 1);
    check("t5_rd_count", rd_log.size(), 1);
    check("t5_words", hs_log.size(), 1);

    // Reset in the middle of a len=16 packet
    clear_logs();
    send(14'h0200, 14'd16);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (hs_log.size() >= 5) break;
    end
    check("t6_wait_words", int'(hs_log.size() >= 5), 1);
    @(posedge clk);
    #1;
    do_reset();
    clear_logs();
    send(14'h0300, 14'd2);
    wait_done(1);
    check("t6_words_after_rst", hs_log.size(), 2);
    check("t6_done_count", done_log.size(), 1);

    // Random descriptors with random backpressure
    ready_mode = 2;
    clear_logs();
    for (int p = 0; p < 25; p++) send(14'($urandom), 14'($urandom_range(0, 12)));
    wait_done(25);
    check("t7_done_count", done_log.size(), 25);
    check("t7_exp_empty", exp_q.size(), 0);
    check("t7_addr_empty", exp_addr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
